// File: rtl/trace_recorder.sv
// Trace capture buffer: records {__obs, start, punti_retta} samples between arm and stop,
// then drains them oldest-first over a valid/ready port. TRACE_RECORDER_WRAP_EN enables overwrite.
module trace_recorder #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          __obs,
    input  logic [7:0]    punti_retta,
    input  logic          arm,
    input  logic          stop,
    input  logic          rd_ready,
    output logic          rd_valid,
    output logic [9:0]    rd_data,
    output logic [AW:0]   count,
    output logic          full,
    output logic          busy,
    output logic          done
);

    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE    = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    typedef enum logic [1:0] {
        StIdle,
        StCapture,
        StHold,
        StDrain
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          rd_valid_q, rd_valid_d;
    logic [9:0]    rd_data_q, rd_data_d;
    logic          done_q, done_d;
    logic          wr_en;
    logic [9:0]    sample;
    logic [9:0]    mem [DEPTH];

    assign sample = {__obs, start, punti_retta};

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        done_d     = 1'b0;
        wr_en      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (arm) begin
                    wr_ptr_d = '0;
                    count_d  = '0;
                    state_d  = StCapture;
                end
            end

            StCapture: begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
`ifdef TRACE_RECORDER_WRAP_EN
                // Once full, each new sample replaces the oldest one.
                if (count_q != FULL_COUNT) begin
                    count_d = count_q + CNT_ONE;
                end
                if (stop) begin
                    state_d = StHold;
                end
`else
                count_d = count_q + CNT_ONE;
                if (stop || (count_d == FULL_COUNT)) begin
                    state_d = StHold;
                end
`endif
            end

            StHold: begin
                if (arm) begin
                    wr_ptr_d = '0;
                    count_d  = '0;
                    state_d  = StCapture;
                end else if (count_q == '0) begin
                    state_d = StIdle;
                end else begin
                    // A full buffer has wr_ptr sitting on the oldest entry.
                    rd_ptr_d   = (count_q == FULL_COUNT) ? wr_ptr_q : '0;
                    rd_valid_d = 1'b0;
                    state_d    = StDrain;
                end
            end

            StDrain: begin
                if (!rd_valid_q) begin
                    rd_data_d  = mem[rd_ptr_q];
                    rd_valid_d = 1'b1;
                end else if (rd_ready) begin
                    rd_ptr_d   = rd_ptr_q + PTR_ONE;
                    count_d    = count_q - CNT_ONE;
                    rd_valid_d = 1'b0;
                    if (count_q == CNT_ONE) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            done_q     <= done_d;
        end
    end

    // Storage is deliberately not reset; count governs what is readable.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= sample;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign count    = count_q;
    assign full     = (count_q == FULL_COUNT);
    assign busy     = (state_q != StIdle);
    assign done     = done_q;

endmodule

// File: tb/tb_trace_recorder.sv
// Self-checking bench for trace_recorder: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_trace_recorder;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    localparam int PIdle  = 0;
    localparam int PCap   = 1;
    localparam int PHold  = 2;
    localparam int PDrain = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          obs = 1'b0;
    logic [7:0]    pr = 8'h00;
    logic          arm = 1'b0;
    logic          stop = 1'b0;
    logic          rd_ready = 1'b0;
    logic          rd_valid;
    logic [9:0]    rd_data;
    logic [AW:0]   count;
    logic          full;
    logic          busy;
    logic          done;

    int checks = 0;
    int failures = 0;

    // Reference model: held entries as a queue, oldest at the front.
    logic [9:0] m_q[$];
    int         m_phase = PIdle;
    logic       m_valid = 1'b0;
    logic       m_done = 1'b0;

    logic [9:0] got[$];
    logic       saw_done;

    trace_recorder #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .__obs      (obs),
        .punti_retta(pr),
        .arm        (arm),
        .stop       (stop),
        .rd_ready   (rd_ready),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .count      (count),
        .full       (full),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_q.delete();
            m_phase = PIdle;
            m_valid = 1'b0;
            m_done  = 1'b0;
        end else begin
            m_done = 1'b0;
            case (m_phase)
                PIdle: begin
                    if (arm) begin
                        m_q.delete();
                        m_phase = PCap;
                    end
                end
                PCap: begin
                    m_q.push_back({obs, start, pr});
`ifdef TRACE_RECORDER_WRAP_EN
                    if (m_q.size() > DEPTH) void'(m_q.pop_front());
                    if (stop) m_phase = PHold;
`else
                    if (stop || m_q.size() == DEPTH) m_phase = PHold;
`endif
                end
                PHold: begin
                    if (arm) begin
                        m_q.delete();
                        m_phase = PCap;
                    end else if (m_q.size() == 0) begin
                        m_phase = PIdle;
                    end else begin
                        m_valid = 1'b0;
                        m_phase = PDrain;
                    end
                end
                default: begin
                    if (!m_valid) begin
                        m_valid = 1'b1;
                    end else if (rd_ready) begin
                        void'(m_q.pop_front());
                        m_valid = 1'b0;
                        if (m_q.size() == 0) begin
                            m_done  = 1'b1;
                            m_phase = PIdle;
                        end
                    end
                end
            endcase
        end
    end

    always @(negedge clock) begin
        check("count", 32'(count), 32'(m_q.size()));
        check("full", 32'(full), 32'(m_q.size() == DEPTH));
        check("busy", 32'(busy), 32'(m_phase != PIdle));
        check("rd_valid", 32'(rd_valid), 32'(m_valid));
        check("done", 32'(done), 32'(m_done));
        if (m_valid) check("rd_data", 32'(rd_data), 32'(m_q[0]));
    end

    task automatic drain_collect(input int budget);
        int n = 0;
        got.delete();
        saw_done = 1'b0;
        rd_ready = 1'b1;
        while (busy && n < budget) begin
            if (rd_valid) got.push_back(rd_data);
            @(negedge clock);
            n++;
            if (done) saw_done = 1'b1;
        end
        check("drain_timeout_busy", 32'(busy), 32'(0));
    endtask

    task automatic check_got(input string name, input int idx, input logic [9:0] exp);
        check(name, (got.size() > idx) ? 32'(got[idx]) : 32'hdead, 32'(exp));
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        @(negedge clock);
        arm = 1'b0;
    endtask

    initial begin
        int base;
        int stop_div;
        int n;

        repeat (3) @(negedge clock);
        check("reset_rd_valid", 32'(rd_valid), 32'(0));
        check("reset_rd_data", 32'(rd_data), 32'(0));
        check("reset_count", 32'(count), 32'(0));
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_done", 32'(done), 32'(0));
        reset = 1'b1;
        @(negedge clock);

        // Three samples, stop on the third, drained in order.
        arm_pulse();
        {obs, start, pr} = {1'b0, 1'b1, 8'h11};
        @(negedge clock);
        {obs, start, pr} = {1'b1, 1'b0, 8'h22};
        @(negedge clock);
        {obs, start, pr} = {1'b1, 1'b1, 8'h33};
        stop = 1'b1;
        @(negedge clock);
        stop = 1'b0;
        check("basic_count", 32'(count), 32'(3));
        drain_collect(50);
        check("basic_n", 32'(got.size()), 32'(3));
        check_got("basic_0", 0, 10'h111);
        check_got("basic_1", 1, 10'h222);
        check_got("basic_2", 2, 10'h333);
        check("basic_done", 32'(saw_done), 32'(1));
        check("basic_end_count", 32'(count), 32'(0));
        rd_ready = 1'b0;
        @(negedge clock);

        // arm and stop together in IDLE: stop ignored, no write on the arm cycle.
        arm = 1'b1;
        stop = 1'b1;
        @(negedge clock);
        arm = 1'b0;
        check("armstop_busy", 32'(busy), 32'(1));
        check("armstop_count", 32'(count), 32'(0));
        {obs, start, pr} = {1'b1, 1'b0, 8'h5a};
        @(negedge clock);
        stop = 1'b0;
        check("armstop_count1", 32'(count), 32'(1));
        drain_collect(50);
        check("armstop_n", 32'(got.size()), 32'(1));
        check_got("armstop_0", 0, 10'h25a);
        rd_ready = 1'b0;
        @(negedge clock);

        // Twenty samples 0..19: saturation or overwrite depending on build.
        arm_pulse();
        for (int i = 0; i < 20; i++) begin
            {obs, start} = 2'b00;
            pr = 8'(i);
`ifdef TRACE_RECORDER_WRAP_EN
            stop = (i == 19);
`endif
            @(negedge clock);
            if (i == 15) begin
                check("sat_full", 32'(full), 32'(1));
                check("sat_count", 32'(count), 32'(16));
            end
        end
        stop = 1'b0;
        check("sat_count_end", 32'(count), 32'(16));
`ifdef TRACE_RECORDER_WRAP_EN
        base = 4;
`else
        base = 0;
`endif
        drain_collect(100);
        check("sat_n", 32'(got.size()), 32'(16));
        for (int i = 0; i < 16; i++) check_got("sat_entry", i, 10'(base + i));
        rd_ready = 1'b0;
        @(negedge clock);

        // Backpressure: rd_ready low for 5 cycles holds the presented entry.
        arm_pulse();
        for (int i = 0; i < 5; i++) begin
            {obs, start} = 2'b00;
            pr = 8'(8'h40 + i);
            stop = (i == 4);
            @(negedge clock);
        end
        stop = 1'b0;
        n = 0;
        while (!rd_valid && n < 10) begin
            @(negedge clock);
            n++;
        end
        check("bp_valid_seen", 32'(rd_valid), 32'(1));
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("bp_hold_valid", 32'(rd_valid), 32'(1));
            check("bp_hold_data", 32'(rd_data), 32'(10'h040));
            check("bp_hold_count", 32'(count), 32'(5));
        end
        drain_collect(50);
        check("bp_n", 32'(got.size()), 32'(5));
        for (int i = 0; i < 5; i++) check_got("bp_entry", i, 10'(8'h40 + i));
        rd_ready = 1'b0;
        @(negedge clock);

        // Asynchronous reset during DRAIN with count=7.
        arm_pulse();
        for (int i = 0; i < 10; i++) begin
            pr = 8'(8'h80 + i);
            stop = (i == 9);
            @(negedge clock);
        end
        stop = 1'b0;
        rd_ready = 1'b1;
        n = 0;
        while (count != 7 && n < 40) begin
            @(negedge clock);
            n++;
        end
        rd_ready = 1'b0;
        check("rst_pre_count", 32'(count), 32'(7));
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("rst_async_valid", 32'(rd_valid), 32'(0));
        check("rst_async_count", 32'(count), 32'(0));
        check("rst_async_busy", 32'(busy), 32'(0));
        check("rst_async_done", 32'(done), 32'(0));
        @(negedge clock);
        reset = 1'b1;
        rd_ready = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_after_valid", 32'(rd_valid), 32'(0));
        check("rst_after_count", 32'(count), 32'(0));
        rd_ready = 1'b0;

        // Randomized traffic against the model.
        stop_div = 3;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) stop_div = ($urandom % 2 == 0) ? 3 : 40;
            arm      = ($urandom % 10) == 0;
            stop     = ($urandom % stop_div) == 0;
            rd_ready = 1'($urandom);
            start    = 1'($urandom);
            obs      = 1'($urandom);
            pr       = 8'($urandom);
            if ($urandom % 500 == 0) begin
                #2 reset = 1'b0;
                #2 reset = 1'b1;
            end
            @(negedge clock);
        end
        arm = 1'b0;
        stop = 1'b0;
        rd_ready = 1'b1;
        repeat (60) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/trace_recorder.md
TRACE_RECORDER -- requirements
Module: trace_recorder

Interface
REQ-001 Parameter DEPTH, default 16, capture entries (power of two, 4..256).
REQ-002 Parameter AW, default 4, address width, equals log2(DEPTH).
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  sampled stimulus bit, opcode bit 0.
REQ-006 __obs  input  1  sampled observation bit, opcode bit 1.
REQ-007 punti_retta  input  8  sampled DUT result.
REQ-008 arm  input  1  single-cycle request to begin a capture.
REQ-009 stop  input  1  single-cycle request to end a capture.
REQ-010 rd_ready  input  1  consumer accepts rd_data.
REQ-011 rd_valid  output  1  rd_data holds an unread entry.
REQ-012 rd_data  output  10  entry {__obs, start, punti_retta[7:0]}.
REQ-013 count  output  AW+1  entries currently held, 0..DEPTH.
REQ-014 full  output  1  count equals DEPTH.
REQ-015 busy  output  1  state is not IDLE.
REQ-016 done  output  1  one-cycle pulse when the last entry is drained.

Function
REQ-017 FSM states: IDLE, CAPTURE, HOLD, DRAIN.
REQ-018 IDLE: arm=1 clears wr_ptr and count, then enters CAPTURE on the next edge.
REQ-019 CAPTURE writes {__obs, start, punti_retta} at wr_ptr on every cycle.
- wr_ptr increments modulo DEPTH.
- count increments and saturates at DEPTH.
REQ-020 stop=1 in CAPTURE: that cycle's sample is still written, then the FSM enters HOLD.
REQ-021 arm is ignored in CAPTURE and DRAIN.
REQ-022 HOLD with count=0 returns to IDLE without pulsing done.
REQ-023 HOLD with count>0 enters DRAIN.
- rd_ptr is set to the oldest entry: wr_ptr if the buffer wrapped, else 0.
REQ-024 DRAIN read path:
- rd_data is registered and rd_valid rises one cycle after DRAIN entry.
- On rd_valid && rd_ready, rd_ptr advances modulo DEPTH and count decrements.
- The next entry is presented the following cycle, so throughput is one entry per two cycles at most.
REQ-025 rd_data is held stable while rd_valid=1 and rd_ready=0.
REQ-026 Last entry accepted (count 1->0): rd_valid falls, done pulses for one cycle, and the FSM enters IDLE on the same edge.
REQ-027 arm=1 in HOLD discards held entries and behaves as REQ-018.
REQ-028 Entries are returned in capture order, oldest first.
REQ-029 full is combinational from count; busy is combinational from state.

Reset
REQ-030 reset=0 asynchronously forces:
- state=IDLE, wr_ptr=0, rd_ptr=0, count=0;
- rd_valid=0, rd_data=0, done=0.
REQ-031 Reset mid-capture or mid-drain discards all held entries.
- Buffer contents need not be cleared.
- After reset deasserts, nothing is readable until the next arm.
REQ-032 Deassertion of reset is sampled on the next rising clock edge.
- A clock edge coincident with deassertion performs no state change.

Configuration
REQ-033 Macro TRACE_RECORDER_WRAP_EN defined: CAPTURE continues after count=DEPTH.
- Newest entries overwrite the oldest.
- count stays at DEPTH and the wrapped flag is set.
- Only stop ends the capture.
REQ-034 Macro TRACE_RECORDER_WRAP_EN undefined: writing the DEPTH-th entry enters HOLD on the same edge, as if stop were asserted.
- No overwrite occurs.
- stop is ignored once count=DEPTH.

Verification
REQ-035 arm, 3 cycles of {__obs,start,punti_retta} = {0,1,0x11}, {1,0,0x22}, {1,1,0x33}, stop on the third, rd_ready=1 -> rd_data 0x111, 0x222, 0x333 in order, then a done pulse, busy=0, count=0.
REQ-036 Without WRAP_EN: arm with no stop, 20 cycles of punti_retta=0..19 -> full=1 after 16 writes, enters HOLD, drain yields 0..15.
REQ-037 With WRAP_EN: arm, 20 cycles of punti_retta=0..19, stop on the 20th -> count=16, drain yields 4..19 oldest first.
REQ-038 In DRAIN hold rd_ready=0 for 5 cycles -> rd_data and rd_valid stable, count unchanged; then rd_ready=1 resumes the sequence.
REQ-039 reset=0 asynchronously during DRAIN with count=7 -> rd_valid=0, count=0, busy=0 immediately; no done pulse.
REQ-040 arm and stop together in IDLE -> stop ignored; CAPTURE entered, first entry written the next cycle.
